time_entry_register: RTL and testbench

//  Consumes the field-select strobes of the time-setting FSM (hour_en/min_en/sec_en,

---
 rtl/time_entry_register_pkg.sv | 34 +++
 rtl/time_entry_register_if.sv | 32 +++
 rtl/time_entry_register_bcd_field_entry.sv | 70 +++++++
 rtl/time_entry_register.sv | 137 +++++++++++++
 tb/tb_time_entry_register.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_entry_register_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | time_entry_pkg : shared state encoding, field widths and BCD helpers for    |
// |                  time_entry_register.                      Revision: 1.0   |
// +----------------------------------------------------------------------------+
package time_entry_pkg;

   localparam int c_DIGIT_W      = 4;
   localparam int c_FIELD_W      = 2 * c_DIGIT_W;
   localparam int c_BIN_W        = 7;
   localparam int c_HOUR_MAX_DEF = 23;
   localparam int c_MIN_MAX_DEF  = 59;
   localparam int c_SEC_MAX_DEF  = 59;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTER    = 2'd1,
      VALIDATE = 2'd2
   } state_t;

   function automatic logic [c_BIN_W-1:0] bcd2bin(input logic [c_FIELD_W-1:0] bcd);
      return c_BIN_W'(bcd[7:4]) * c_BIN_W'(10) + c_BIN_W'(bcd[3:0]);
   endfunction

   function automatic logic [c_FIELD_W-1:0] bin2bcd(input int unsigned val);
      logic [c_DIGIT_W-1:0] tens;
      logic [c_DIGIT_W-1:0] ones;
      tens = c_DIGIT_W'(val / 10);
      ones = c_DIGIT_W'(val % 10);
      return {tens, ones};
   endfunction

endpackage
`default_nettype wire

// File: rtl/time_entry_register_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | time_entry_register_if : field strobes, keypad and committed-time bundle.   |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
interface time_entry_register_if;
   import time_entry_pkg::*;

   logic                 hour_en;
   logic                 min_en;
   logic                 sec_en;
   logic                 completeSetting;
   logic                 key_valid;
   logic [c_DIGIT_W-1:0] key_digit;
   logic [c_FIELD_W-1:0] set_hour;
   logic [c_FIELD_W-1:0] set_min;
   logic [c_FIELD_W-1:0] set_sec;
   logic                 load_pulse;
   logic                 entry_err;

   modport master (
      output hour_en, min_en, sec_en, completeSetting, key_valid, key_digit,
      input  set_hour, set_min, set_sec, load_pulse, entry_err
   );

   modport slave (
      input  hour_en, min_en, sec_en, completeSetting, key_valid, key_digit,
      output set_hour, set_min, set_sec, load_pulse, entry_err
   );

endinterface
`default_nettype wire

// File: rtl/time_entry_register_bcd_field_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_field_entry : one 2-digit BCD field with edge-triggered clear/commit    |
// |                   and its staging register.                Revision: 1.0   |
// +----------------------------------------------------------------------------+
module bcd_field_entry
   import time_entry_pkg::*;
(
   input  wire logic                 clock,
   input  wire logic                 reset,
   input  wire logic                 field_en,
   input  wire logic                 field_active,
   input  wire logic                 key_valid,
   input  wire logic [c_DIGIT_W-1:0] key_digit,
   input  wire logic                 load,
   input  wire logic [c_FIELD_W-1:0] load_value,
   output logic      [c_FIELD_W-1:0] staged
);

   logic                 r_en_d;
   logic [c_FIELD_W-1:0] r_buf;
   logic [1:0]           r_count;
   logic [c_FIELD_W-1:0] r_staged;

   logic                 w_rise;
   logic                 w_fall;
   logic                 w_key;
   logic [c_FIELD_W-1:0] w_buf_base;
   logic [1:0]           w_cnt_base;
   logic [c_FIELD_W-1:0] w_buf_nxt;
   logic [1:0]           w_cnt_nxt;

   assign w_rise = field_en & ~r_en_d;
   assign w_fall = ~field_en & r_en_d;
   assign w_key  = key_valid & field_active & (key_digit <= 4'd9);

   // A key arriving with the rising edge lands in the freshly cleared buffer.
   always_comb begin
      w_buf_base = w_rise ? '0 : r_buf;
      w_cnt_base = w_rise ? 2'd0 : r_count;
      w_buf_nxt  = w_buf_base;
      w_cnt_nxt  = w_cnt_base;
      if (w_key && (w_cnt_base < 2'd2)) begin
         w_buf_nxt = {w_buf_base[3:0], key_digit};
         w_cnt_nxt = w_cnt_base + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_en_d   <= 1'b0;
         r_buf    <= '0;
         r_count  <= 2'd0;
         r_staged <= '0;
      end else begin
         r_en_d  <= field_en;
         r_buf   <= w_buf_nxt;
         r_count <= w_cnt_nxt;
         if (w_fall && (r_count != 2'd0)) begin
            r_staged <= r_buf;
         end else if (load) begin
            r_staged <= load_value;
         end
      end
   end

   assign staged = r_staged;

endmodule
`default_nettype wire

// File: rtl/time_entry_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | time_entry_register : keypad HH:MM:SS entry, range check and commit.        |
// | Option macro TIME_ENTRY_CLAMP_EN clamps bad fields instead of rejecting.    |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
module time_entry_register
   import time_entry_pkg::*;
#(
   parameter int HOUR_MAX = c_HOUR_MAX_DEF,
   parameter int MIN_MAX  = c_MIN_MAX_DEF,
   parameter int SEC_MAX  = c_SEC_MAX_DEF
) (
   input  wire logic             clock,
   input  wire logic             reset,
   time_entry_register_if.slave  bus
);

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_load_stage;
   logic                 w_any_en;

   logic [c_FIELD_W-1:0] w_stage_hour;
   logic [c_FIELD_W-1:0] w_stage_min;
   logic [c_FIELD_W-1:0] w_stage_sec;
   logic                 w_hour_oor;
   logic                 w_min_oor;
   logic                 w_sec_oor;
   logic                 w_any_oor;

   logic [c_FIELD_W-1:0] r_set_hour;
   logic [c_FIELD_W-1:0] r_set_min;
   logic [c_FIELD_W-1:0] r_set_sec;
   logic                 r_load_pulse;
   logic                 r_entry_err;

   logic                 w_hour_act;
   logic                 w_min_act;
   logic                 w_sec_act;

   assign w_any_en   = bus.hour_en | bus.min_en | bus.sec_en;
   assign w_hour_act = bus.hour_en;
   assign w_min_act  = bus.min_en & ~bus.hour_en;
   assign w_sec_act  = bus.sec_en & ~bus.hour_en & ~bus.min_en;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_load_stage = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.completeSetting) begin
               w_next_state = VALIDATE;
            end else if (w_any_en) begin
               w_next_state = ENTER;
               w_load_stage = 1'b1;
            end
         end
         ENTER:    if (bus.completeSetting) w_next_state = VALIDATE;
         VALIDATE: w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   bcd_field_entry u_hour (
      .clock(clock), .reset(reset), .field_en(bus.hour_en), .field_active(w_hour_act),
      .key_valid(bus.key_valid), .key_digit(bus.key_digit), .load(w_load_stage),
      .load_value(r_set_hour), .staged(w_stage_hour)
   );

   bcd_field_entry u_min (
      .clock(clock), .reset(reset), .field_en(bus.min_en), .field_active(w_min_act),
      .key_valid(bus.key_valid), .key_digit(bus.key_digit), .load(w_load_stage),
      .load_value(r_set_min), .staged(w_stage_min)
   );

   bcd_field_entry u_sec (
      .clock(clock), .reset(reset), .field_en(bus.sec_en), .field_active(w_sec_act),
      .key_valid(bus.key_valid), .key_digit(bus.key_digit), .load(w_load_stage),
      .load_value(r_set_sec), .staged(w_stage_sec)
   );

   assign w_hour_oor = bcd2bin(w_stage_hour) > c_BIN_W'(HOUR_MAX);
   assign w_min_oor  = bcd2bin(w_stage_min)  > c_BIN_W'(MIN_MAX);
   assign w_sec_oor  = bcd2bin(w_stage_sec)  > c_BIN_W'(SEC_MAX);
   assign w_any_oor  = w_hour_oor | w_min_oor | w_sec_oor;

`ifdef TIME_ENTRY_CLAMP_EN
   localparam logic [c_FIELD_W-1:0] c_HOUR_CLAMP = bin2bcd(HOUR_MAX);
   localparam logic [c_FIELD_W-1:0] c_MIN_CLAMP  = bin2bcd(MIN_MAX);
   localparam logic [c_FIELD_W-1:0] c_SEC_CLAMP  = bin2bcd(SEC_MAX);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_set_hour   <= '0;
         r_set_min    <= '0;
         r_set_sec    <= '0;
         r_load_pulse <= 1'b0;
         r_entry_err  <= 1'b0;
      end else begin
         r_load_pulse <= 1'b0;
         r_entry_err  <= 1'b0;
         if (r_state == VALIDATE) begin
`ifdef TIME_ENTRY_CLAMP_EN
            r_set_hour   <= w_hour_oor ? c_HOUR_CLAMP : w_stage_hour;
            r_set_min    <= w_min_oor  ? c_MIN_CLAMP  : w_stage_min;
            r_set_sec    <= w_sec_oor  ? c_SEC_CLAMP  : w_stage_sec;
            r_load_pulse <= 1'b1;
            r_entry_err  <= w_any_oor;
`else
            if (w_any_oor) begin
               r_entry_err <= 1'b1;
            end else begin
               r_set_hour   <= w_stage_hour;
               r_set_min    <= w_stage_min;
               r_set_sec    <= w_stage_sec;
               r_load_pulse <= 1'b1;
            end
`endif
         end
      end
   end

   assign bus.set_hour   = r_set_hour;
   assign bus.set_min    = r_set_min;
   assign bus.set_sec    = r_set_sec;
   assign bus.load_pulse = r_load_pulse;
   assign bus.entry_err  = r_entry_err;

endmodule
`default_nettype wire

// File: tb/tb_time_entry_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_time_entry_register : directed and random entry sequences against a     |
// |                          decimal model of the committed time. Rev: 1.0    |
// +----------------------------------------------------------------------------+
module tb_time_entry_register;

   logic clock;
   logic reset;

   time_entry_register_if bus ();

   time_entry_register dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state, fields in decimal: index 0 hour, 1 minute, 2 second.
   int stage[3];
   int setv[3];
   int maxv[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic set_en(input int f, input logic v);
      case (f)
         0:       bus.hour_en = v;
         1:       bus.min_en  = v;
         default: bus.sec_en  = v;
      endcase
   endtask

   task automatic start_txn();
      stage = setv;
   endtask

   task automatic enter_field(input int f, input int n, input int k0, input int k1,
                              input int k2, input int k3, input bit same);
      int keys[4];
      int cnt;
      int val;
      int first;
      keys[0] = k0; keys[1] = k1; keys[2] = k2; keys[3] = k3;
      cnt = 0; val = 0; first = 0;
      for (int i = 0; i < n; i++) begin
         if (keys[i] <= 9 && cnt < 2) begin
            val = (val % 10) * 10 + keys[i];
            cnt++;
         end
      end
      set_en(f, 1'b1);
      if (same && n > 0) begin
         bus.key_valid = 1'b1;
         bus.key_digit = 4'(keys[0]);
         first = 1;
      end
      @(negedge clock);
      bus.key_valid = 1'b0;
      for (int i = first; i < n; i++) begin
         bus.key_valid = 1'b1;
         bus.key_digit = 4'(keys[i]);
         @(negedge clock);
         bus.key_valid = 1'b0;
      end
      set_en(f, 1'b0);
      @(negedge clock);
      if (cnt > 0) stage[f] = val;
   endtask

   task automatic check_set(input string tag);
      check({tag, ".hour"}, 32'(bus.set_hour), 32'(to_bcd(setv[0])));
      check({tag, ".min"},  32'(bus.set_min),  32'(to_bcd(setv[1])));
      check({tag, ".sec"},  32'(bus.set_sec),  32'(to_bcd(setv[2])));
   endtask

   task automatic complete(input string tag);
      bit oor;
      bit exp_pulse;
      bit exp_err;
      oor = 1'b0;
      for (int i = 0; i < 3; i++) if (stage[i] > maxv[i]) oor = 1'b1;
`ifdef TIME_ENTRY_CLAMP_EN
      for (int i = 0; i < 3; i++) setv[i] = (stage[i] > maxv[i]) ? maxv[i] : stage[i];
      exp_pulse = 1'b1;
      exp_err   = oor;
`else
      if (oor) begin
         exp_pulse = 1'b0;
         exp_err   = 1'b1;
      end else begin
         setv      = stage;
         exp_pulse = 1'b1;
         exp_err   = 1'b0;
      end
`endif
      bus.completeSetting = 1'b1;
      @(negedge clock);
      bus.completeSetting = 1'b0;
      check({tag, ".n1_pulse"}, 32'(bus.load_pulse), 32'd0);
      check({tag, ".n1_err"},   32'(bus.entry_err),  32'd0);
      @(negedge clock);
      check({tag, ".pulse"}, 32'(bus.load_pulse), 32'(exp_pulse));
      check({tag, ".err"},   32'(bus.entry_err),  32'(exp_err));
      check_set(tag);
      @(negedge clock);
      check({tag, ".n3_pulse"}, 32'(bus.load_pulse), 32'd0);
      check({tag, ".n3_err"},   32'(bus.entry_err),  32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         stage[i] = 0;
         setv[i]  = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   initial begin
      maxv[0] = 23; maxv[1] = 59; maxv[2] = 59;
      model_reset();
      reset = 1'b1;
      bus.hour_en = 1'b0; bus.min_en = 1'b0; bus.sec_en = 1'b0;
      bus.completeSetting = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      repeat (2) @(negedge clock);
      check("rst.pulse", 32'(bus.load_pulse), 32'd0);
      check("rst.err",   32'(bus.entry_err),  32'd0);
      check_set("rst");
      reset = 1'b0;
      @(negedge clock);

      // Full entry of 12:34:56.
      start_txn();
      enter_field(0, 2, 1, 2, 0, 0, 1'b0);
      enter_field(1, 2, 3, 4, 0, 0, 1'b0);
      enter_field(2, 2, 5, 6, 0, 0, 1'b0);
      complete("t1");

      // Hour 25 is out of range.
      start_txn();
      enter_field(0, 2, 2, 5, 0, 0, 1'b0);
      complete("t2");

      // Single-digit minute, then an empty minute entry.
      start_txn();
      enter_field(1, 1, 7, 0, 0, 0, 1'b0);
      complete("t3a");
      start_txn();
      enter_field(1, 0, 0, 0, 0, 0, 1'b0);
      complete("t3b");

      // Third digit and non-digit key ignored.
      start_txn();
      enter_field(0, 4, 1, 2, 9, 11, 1'b0);
      complete("t4");

      // Overlapping enables: hour wins the keys, minute has no digits.
      start_txn();
      bus.hour_en = 1'b1; bus.min_en = 1'b1;
      @(negedge clock);
      bus.key_valid = 1'b1; bus.key_digit = 4'd0;
      @(negedge clock);
      bus.key_digit = 4'd8;
      @(negedge clock);
      bus.key_valid = 1'b0; bus.hour_en = 1'b0; bus.min_en = 1'b0;
      @(negedge clock);
      stage[0] = 8;
      complete("prio");

      // Reset in the middle of an entry, then revalidate the cleared staging.
      start_txn();
      bus.hour_en = 1'b1;
      @(negedge clock);
      bus.key_valid = 1'b1; bus.key_digit = 4'd1;
      @(negedge clock);
      bus.key_digit = 4'd2;
      @(negedge clock);
      bus.key_valid = 1'b0; bus.hour_en = 1'b0;
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      check("t5.rst_pulse", 32'(bus.load_pulse), 32'd0);
      check("t5.rst_err",   32'(bus.entry_err),  32'd0);
      check_set("t5.rst");
      reset = 1'b0;
      @(negedge clock);
      complete("t5");

      // Reset during VALIDATE suppresses the commit.
      start_txn();
      enter_field(0, 2, 1, 1, 0, 0, 1'b0);
      complete("t5b_pre");
      start_txn();
      enter_field(1, 2, 2, 2, 0, 0, 1'b0);
      bus.completeSetting = 1'b1;
      @(negedge clock);
      bus.completeSetting = 1'b0;
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      check("t5b.pulse", 32'(bus.load_pulse), 32'd0);
      check("t5b.err",   32'(bus.entry_err),  32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("t5b.n3_pulse", 32'(bus.load_pulse), 32'd0);
      check("t5b.n3_err",   32'(bus.entry_err),  32'd0);
      check_set("t5b");

      // Digit in the same cycle as the minute enable rises.
      start_txn();
      enter_field(1, 1, 4, 0, 0, 0, 1'b1);
      complete("t6");

      // Random sequences, including bare completeSetting revalidation.
      for (int t = 0; t < 40; t++) begin
         int nf;
         int lim;
         int k[4];
         nf = $urandom_range(0, 3);
         if (nf > 0) start_txn();
         for (int j = 0; j < nf; j++) begin
            int f;
            int nk;
            f   = $urandom_range(0, 2);
            nk  = $urandom_range(0, 4);
            lim = ($urandom_range(0, 1) == 1) ? 5 : 9;
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(0, 4) == 0) k[i] = $urandom_range(10, 15);
               else                           k[i] = $urandom_range(0, lim);
            end
            enter_field(f, nk, k[0], k[1], k[2], k[3], 1'($urandom_range(0, 1)));
         end
         complete($sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
